// File: rtl/pwm_keys_multi.sv
// pwm_keys_multi
//   Multi-channel PWM with one shared period counter. Each channel has a
//   pending (shadow) level and an active level. Debounced inc/dec keys step
//   the pending level of the channel chosen by sel. Pending levels are copied
//   to the active levels only at the period wrap, so no output glitches
//   mid-period.
//
// Ports
//   in           clock, rising edge
//   rst          asynchronous reset, active-high
//   inc, dec     raw asynchronous keys, active-high
//   sel          channel targeted by key steps, sampled on the step cycle
//   pwm          PWM outputs, bit i belongs to channel i
//   level_o      active level of channel sel (0 when sel is out of range)
//   period_start high while the period counter is 0
module pwm_keys_multi #(
  parameter int CHANNELS    = 4,
  parameter int WIDTH       = 4,
  parameter int MAX_LEVEL   = 10,
  parameter int RESET_LEVEL = 5,
  parameter int DEBOUNCE    = 4,
  parameter int SEL_W       = 2,
  parameter bit INVERT      = 1'b0
) (
  input  logic                in,
  input  logic                rst,
  input  logic                inc,
  input  logic                dec,
  input  logic [SEL_W-1:0]    sel,
  output logic [CHANNELS-1:0] pwm,
  output logic [WIDTH-1:0]    level_o,
  output logic                period_start
);

  localparam int CNT_W = (DEBOUNCE > 1) ? $clog2(DEBOUNCE) : 1;

  localparam logic [WIDTH-1:0] LAST_CNT  = WIDTH'(MAX_LEVEL - 1);
  localparam logic [WIDTH-1:0] TOP_LVL   = WIDTH'(MAX_LEVEL);
  localparam logic [WIDTH-1:0] RST_LVL   = WIDTH'(RESET_LEVEL);
  localparam logic [CNT_W-1:0] DB_LAST   = CNT_W'(DEBOUNCE - 1);

  // Key index 0 is inc, 1 is dec.
  logic [1:0]       raw;
  logic [1:0]       sync_a;
  logic [1:0]       sync_b;
  logic [1:0]       db;
  logic [1:0]       db_q;
  logic [1:0]       step;
  logic [CNT_W-1:0] db_cnt [2];

  logic [WIDTH-1:0] counter;
  logic             wrap;
  logic             do_inc;
  logic             do_dec;
  logic [WIDTH-1:0] pending [CHANNELS];
  logic [WIDTH-1:0] active  [CHANNELS];

  assign raw = {dec, inc};

  // Synchroniser, debouncer and rising-edge step pulse for both keys.
  // NOTE: every sequential block uses non-blocking (<=) assignments so all
  // registers update together from pre-edge values; blocking assignments
  // here would let later statements see half-updated state.
  always_ff @(posedge in or posedge rst) begin
    if (rst) begin
      sync_a <= '0;
      sync_b <= '0;
      db     <= '0;
      db_q   <= '0;
      step   <= '0;
      for (int k = 0; k < 2; k++) db_cnt[k] <= '0;
    end else begin
      sync_a <= raw;
      sync_b <= sync_a;
      db_q   <= db;
      // Step fires the cycle after the debounced value rises; release is silent.
      step   <= db & ~db_q;
      for (int k = 0; k < 2; k++) begin
        if (sync_b[k] != db[k]) begin
          if (db_cnt[k] == DB_LAST) begin
            db[k]     <= ~db[k];
            db_cnt[k] <= '0;
          end else begin
            db_cnt[k] <= db_cnt[k] + 1'b1;
          end
        end else begin
          db_cnt[k] <= '0;
        end
      end
    end
  end

  assign wrap   = (counter == LAST_CNT);
  // Simultaneous inc and dec steps cancel.
  assign do_inc = step[0] & ~step[1];
  assign do_dec = step[1] & ~step[0];

  always_ff @(posedge in or posedge rst) begin
    if (rst) counter <= '0;
    else     counter <= wrap ? '0 : counter + 1'b1;
  end

  // NOTE: the level arrays are a handful of flip-flops, not a RAM, so they
  // take a reset like any other register.
  always_ff @(posedge in or posedge rst) begin
    if (rst) begin
      for (int i = 0; i < CHANNELS; i++) begin
        pending[i] <= RST_LVL;
        active[i]  <= RST_LVL;
      end
    end else begin
      // The load copies pre-edge pending values, so a step on the wrap edge
      // itself is only picked up at the following wrap.
      if (wrap) begin
        for (int i = 0; i < CHANNELS; i++) active[i] <= pending[i];
      end
      // A sel value with no matching channel matches no iteration: step ignored.
      for (int i = 0; i < CHANNELS; i++) begin
        if (int'(sel) == i) begin
          if (do_inc && pending[i] != TOP_LVL) pending[i] <= pending[i] + 1'b1;
          if (do_dec && pending[i] != '0)      pending[i] <= pending[i] - 1'b1;
        end
      end
    end
  end

  // NOTE: every output of an always_comb gets a default before any
  // conditional assignment, so no path leaves it unassigned (no latch).
  always_comb begin
    level_o = '0;
    for (int i = 0; i < CHANNELS; i++) begin
      if (int'(sel) == i) level_o = active[i];
    end
  end

  always_comb begin
    pwm = '0;
    for (int i = 0; i < CHANNELS; i++) pwm[i] = (counter < active[i]) ^ INVERT;
  end

  assign period_start = (counter == '0);

endmodule

// File: tb/tb_pwm_keys_multi.sv
// Testbench for pwm_keys_multi. Three instances share the stimulus:
// default parameters, INVERT=1, and CHANNELS=3. The reference model tracks
// per-channel pending/active levels as plain integers and derives expected
// waveforms from the rule "high for the first L cycles of each period".
module tb_pwm_keys_multi;

  localparam int ML = 10;
  localparam int RL = 5;

  logic       clk = 1'b0;
  logic       rst;
  logic       inc;
  logic       dec;
  logic [1:0] sel;

  logic [3:0] pwm_m, pwm_i;
  logic [2:0] pwm_c;
  logic [3:0] lvl_m, lvl_i, lvl_c;
  logic       ps_m, ps_i, ps_c;

  int tests_run = 0;
  int fails     = 0;

  int m_pend [4];
  int m_act  [4];
  int c_pend [3];
  int c_act  [3];

  logic [ML-1:0] cap_m [4];
  logic [ML-1:0] cap_i [4];
  logic [ML-1:0] cap_c [3];
  logic [ML-1:0] cap_ps;

  pwm_keys_multi dut_m (
    .in(clk), .rst(rst), .inc(inc), .dec(dec), .sel(sel),
    .pwm(pwm_m), .level_o(lvl_m), .period_start(ps_m)
  );

  pwm_keys_multi #(.INVERT(1'b1)) dut_i (
    .in(clk), .rst(rst), .inc(inc), .dec(dec), .sel(sel),
    .pwm(pwm_i), .level_o(lvl_i), .period_start(ps_i)
  );

  pwm_keys_multi #(.CHANNELS(3)) dut_c (
    .in(clk), .rst(rst), .inc(inc), .dec(dec), .sel(sel),
    .pwm(pwm_c), .level_o(lvl_c), .period_start(ps_c)
  );

  always #5 clk = ~clk;

  initial begin
    #400000;
    $display("FAIL watchdog: simulation did not finish in time");
    $fatal(1);
  end

  // Expected non-inverted waveform for level lvl: bit t is the output while counter==t.
  function automatic logic [ML-1:0] wave_of(input int lvl);
    logic [ML-1:0] w;
    w = '0;
    for (int t = 0; t < ML; t++) w[t] = (t < lvl);
    return w;
  endfunction

  task automatic model_reset();
    for (int i = 0; i < 4; i++) begin m_pend[i] = RL; m_act[i] = RL; end
    for (int i = 0; i < 3; i++) begin c_pend[i] = RL; c_act[i] = RL; end
  endtask

  task automatic model_step(input bit up, input int ch);
    if (ch < 4) m_pend[ch] = up ? ((m_pend[ch] < ML) ? m_pend[ch] + 1 : ML)
                                : ((m_pend[ch] > 0) ? m_pend[ch] - 1 : 0);
    if (ch < 3) c_pend[ch] = up ? ((c_pend[ch] < ML) ? c_pend[ch] + 1 : ML)
                                : ((c_pend[ch] > 0) ? c_pend[ch] - 1 : 0);
  endtask

  // Advance to the next negedge where the counter is 0 (bounded).
  task automatic wait_ps();
    bit found = 1'b0;
    for (int n = 0; n < 3 * ML && !found; n++) begin
      @(negedge clk);
      if (ps_m) found = 1'b1;
    end
    if (!found) begin
      tests_run++;
      fails++;
      $display("FAIL period_start_timeout: no pulse seen within %0d cycles", 3 * ML);
    end
  endtask

  // Align to a period start, commit pending->active in the model, record one period.
  task automatic capture_period();
    wait_ps();
    for (int i = 0; i < 4; i++) m_act[i] = m_pend[i];
    for (int i = 0; i < 3; i++) c_act[i] = c_pend[i];
    for (int t = 0; t < ML; t++) begin
      if (t > 0) @(negedge clk);
      for (int i = 0; i < 4; i++) begin cap_m[i][t] = pwm_m[i]; cap_i[i][t] = pwm_i[i]; end
      for (int i = 0; i < 3; i++) cap_c[i][t] = pwm_c[i];
      cap_ps[t] = ps_m;
    end
  endtask

  // Clean key press on channel ch, called at a negedge.
  task automatic press(input bit up, input int ch, input int hold, input int gap);
    sel = 2'(ch);
    if (up) inc = 1'b1; else dec = 1'b1;
    repeat (hold) @(negedge clk);
    inc = 1'b0;
    dec = 1'b0;
    repeat (gap) @(negedge clk);
    model_step(up, ch);
  endtask

  task automatic test_reset();
    rst = 1'b1; inc = 1'b0; dec = 1'b0; sel = 2'd0;
    model_reset();
    repeat (2) @(negedge clk);
    tests_run++;
    if (pwm_m !== 4'hF || pwm_i !== 4'h0 || pwm_c !== 3'h7) begin
      fails++;
      $display("FAIL reset_pwm: got %h/%h/%h want f/0/7", pwm_m, pwm_i, pwm_c);
    end
    tests_run++;
    if (ps_m !== 1'b1 || ps_i !== 1'b1 || ps_c !== 1'b1 || lvl_m !== 4'(RL)) begin
      fails++;
      $display("FAIL reset_ps_level: ps=%b%b%b level=%0d want 111 level=%0d",
               ps_m, ps_i, ps_c, lvl_m, RL);
    end
    rst = 1'b0;
    for (int p = 0; p < 2; p++) begin
      capture_period();
      tests_run++;
      if (cap_ps !== 10'h001) begin
        fails++;
        $display("FAIL reset_period_start: got %b want %b", cap_ps, 10'h001);
      end
      for (int i = 0; i < 4; i++) begin
        tests_run++;
        if (cap_m[i] !== wave_of(m_act[i]) || cap_i[i] !== ~wave_of(m_act[i])) begin
          fails++;
          $display("FAIL reset_wave ch%0d: got %b/%b want %b/%b", i, cap_m[i], cap_i[i],
                   wave_of(m_act[i]), ~wave_of(m_act[i]));
        end
      end
    end
  endtask

  task automatic test_single_step();
    // Press at counter 1: step lands at the end of counter 8, visible next period.
    wait_ps();
    @(negedge clk);
    sel = 2'd2;
    inc = 1'b1;
    wait_ps();
    tests_run++;
    if (lvl_m !== 4'd6 || lvl_c !== 4'd6) begin
      fails++;
      $display("FAIL step_latency_early: level got %0d/%0d want 6", lvl_m, lvl_c);
    end
    repeat (11) @(negedge clk);
    inc = 1'b0;
    repeat (10) @(negedge clk);
    model_step(1'b1, 2);
    capture_period();
    for (int i = 0; i < 4; i++) begin
      tests_run++;
      if (cap_m[i] !== wave_of(m_act[i]) || cap_i[i] !== ~wave_of(m_act[i])) begin
        fails++;
        $display("FAIL single_step_wave ch%0d: got %b/%b want %b", i, cap_m[i], cap_i[i],
                 wave_of(m_act[i]));
      end
    end
    // Press at counter 2: step lands on the wrap edge and misses that load.
    wait_ps();
    repeat (2) @(negedge clk);
    inc = 1'b1;
    wait_ps();
    tests_run++;
    if (lvl_m !== 4'd6) begin
      fails++;
      $display("FAIL shadow_same_edge: level got %0d want 6 (old)", lvl_m);
    end
    repeat (ML) @(negedge clk);
    tests_run++;
    if (lvl_m !== 4'd7 || lvl_c !== 4'd7) begin
      fails++;
      $display("FAIL shadow_next_wrap: level got %0d/%0d want 7", lvl_m, lvl_c);
    end
    inc = 1'b0;
    repeat (10) @(negedge clk);
    model_step(1'b1, 2);
  endtask

  task automatic test_saturation();
    for (int n = 0; n < 7; n++) press(1'b1, 0, 8, 8);
    capture_period();
    tests_run++;
    if (cap_m[0] !== wave_of(ML) || cap_i[0] !== ~wave_of(ML) || cap_c[0] !== wave_of(ML)
        || lvl_m !== 4'(ML)) begin
      fails++;
      $display("FAIL saturate_high: got %b/%b/%b level=%0d want all high level=%0d",
               cap_m[0], cap_i[0], cap_c[0], lvl_m, ML);
    end
    for (int n = 0; n < 11; n++) press(1'b0, 0, 8, 8);
    capture_period();
    tests_run++;
    if (cap_m[0] !== wave_of(0) || cap_i[0] !== ~wave_of(0) || cap_c[0] !== wave_of(0)
        || lvl_m !== 4'd0) begin
      fails++;
      $display("FAIL saturate_low: got %b/%b/%b level=%0d want all low level=0",
               cap_m[0], cap_i[0], cap_c[0], lvl_m);
    end
  endtask

  task automatic test_bounce();
    sel = 2'd1;
    for (int n = 0; n < 15; n++) begin
      inc = ~inc;
      repeat (2) @(negedge clk);
    end
    inc = 1'b0;
    repeat (10) @(negedge clk);
    capture_period();
    tests_run++;
    if (cap_m[1] !== wave_of(m_act[1]) || cap_c[1] !== wave_of(c_act[1])) begin
      fails++;
      $display("FAIL bounce_no_step: got %b/%b want %b", cap_m[1], cap_c[1], wave_of(m_act[1]));
    end
    press(1'b1, 1, 20, 10);
    capture_period();
    tests_run++;
    if (cap_m[1] !== wave_of(m_act[1]) || cap_c[1] !== wave_of(c_act[1])) begin
      fails++;
      $display("FAIL bounce_then_stable: got %b/%b want %b", cap_m[1], cap_c[1],
               wave_of(m_act[1]));
    end
  endtask

  task automatic test_simultaneous();
    sel = 2'd3;
    inc = 1'b1;
    dec = 1'b1;
    repeat (20) @(negedge clk);
    inc = 1'b0;
    dec = 1'b0;
    repeat (10) @(negedge clk);
    press(1'b1, 3, 10, 10);
    capture_period();
    for (int i = 0; i < 4; i++) begin
      tests_run++;
      if (cap_m[i] !== wave_of(m_act[i])) begin
        fails++;
        $display("FAIL simul_sel3 ch%0d: got %b want %b", i, cap_m[i], wave_of(m_act[i]));
      end
    end
    for (int i = 0; i < 3; i++) begin
      tests_run++;
      if (cap_c[i] !== wave_of(c_act[i])) begin
        fails++;
        $display("FAIL sel_out_of_range ch%0d: got %b want %b", i, cap_c[i], wave_of(c_act[i]));
      end
    end
    tests_run++;
    if (lvl_m !== 4'(m_act[3])) begin
      fails++;
      $display("FAIL level_sel3: got %0d want %0d", lvl_m, m_act[3]);
    end
  endtask

  task automatic test_random();
    for (int n = 0; n < 24; n++) begin
      press(1'($urandom_range(0, 1)), int'($urandom_range(0, 3)),
            int'($urandom_range(7, 15)), int'($urandom_range(8, 14)));
      if (n % 6 == 5) begin
        capture_period();
        for (int i = 0; i < 4; i++) begin
          tests_run++;
          if (cap_m[i] !== wave_of(m_act[i]) || cap_i[i] !== ~wave_of(m_act[i])) begin
            fails++;
            $display("FAIL random_wave ch%0d: got %b/%b want %b", i, cap_m[i], cap_i[i],
                     wave_of(m_act[i]));
          end
        end
        for (int i = 0; i < 3; i++) begin
          tests_run++;
          if (cap_c[i] !== wave_of(c_act[i])) begin
            fails++;
            $display("FAIL random_wave_c3 ch%0d: got %b want %b", i, cap_c[i], wave_of(c_act[i]));
          end
        end
        sel = 2'($urandom_range(0, 3));
        #1;
        tests_run++;
        if (lvl_m !== 4'(m_act[sel]) || lvl_i !== 4'(m_act[sel])) begin
          fails++;
          $display("FAIL random_level sel%0d: got %0d/%0d want %0d", sel, lvl_m, lvl_i, m_act[sel]);
        end
        @(negedge clk);
      end
    end
  endtask

  task automatic test_reset_mid();
    int cyc;
    for (int n = 0; n < 12 && m_pend[1] != 8; n++) press(m_pend[1] < 8, 1, 8, 8);
    capture_period();
    tests_run++;
    if (cap_m[1] !== wave_of(8)) begin
      fails++;
      $display("FAIL mid_setup ch1: got %b want %b", cap_m[1], wave_of(8));
    end
    sel = 2'd1;
    inc = 1'b1;
    repeat (8) @(negedge clk);
    #2 rst = 1'b1;
    #1;
    model_reset();
    tests_run++;
    if (pwm_m !== 4'hF || pwm_i !== 4'h0 || pwm_c !== 3'h7 || ps_m !== 1'b1
        || lvl_m !== 4'(RL) || lvl_c !== 4'(RL)) begin
      fails++;
      $display("FAIL async_reset: pwm=%h/%h/%h ps=%b level=%0d/%0d want f/0/7 ps=1 level=%0d",
               pwm_m, pwm_i, pwm_c, ps_m, lvl_m, lvl_c, RL);
    end
    repeat (3) @(negedge clk);
    rst = 1'b0;
    cyc = 0;
    for (int n = 1; n <= 3 * ML && cyc == 0; n++) begin
      @(negedge clk);
      if (ps_m) cyc = n;
    end
    tests_run++;
    if (cyc != ML) begin
      fails++;
      $display("FAIL restart_counter: period_start after %0d cycles want %0d", cyc, ML);
    end
    // Key held through reset release: debounced afresh, one step.
    repeat (20) @(negedge clk);
    inc = 1'b0;
    repeat (10) @(negedge clk);
    model_step(1'b1, 1);
    capture_period();
    for (int i = 0; i < 4; i++) begin
      tests_run++;
      if (cap_m[i] !== wave_of(m_act[i]) || cap_i[i] !== ~wave_of(m_act[i])) begin
        fails++;
        $display("FAIL after_reset ch%0d: got %b/%b want %b", i, cap_m[i], cap_i[i],
                 wave_of(m_act[i]));
      end
    end
  endtask

  initial begin
    test_reset();
    test_single_step();
    test_saturation();
    test_bounce();
    test_simultaneous();
    test_random();
    test_reset_mid();
    $display("[TB] %0d tests run, %0d failed", tests_run, fails);
    $finish;
  end

endmodule
